time_entry: RTL and testbench
=============================

Name: time_entry

Overview:
Keypad-side writer for the microwave countdown chain. It collects BCD digits typed by the user into an mm:ss buffer and validates them. On start it drives the parallel-load interface (data plus active-low loadn) of the mod-10/mod-6 countdown counters, then gates their enable until the timer reports zero or the user cancels. Sits between the keypad decoder and the timer counter chain.

Parameters:
DIGITS, 4, number of BCD digits buffered (sec_ones, sec_tens, min_ones, min_tens)
QUICK_SEC_TENS, 3, sec_tens value loaded by quick start (only with QUICK_START_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  reset; one clock, synchronous, active-high
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  keypad code; 0-9 digits, 10-15 illegal
start  input  1  one-cycle start strobe
cancel  input  1  one-cycle cancel/stop strobe
zero  input  1  timer chain reports 00:00 (from counter zero flags)
sec_ones  output  4  BCD load data, seconds ones
sec_tens  output  4  BCD load data, seconds tens
min_ones  output  4  BCD load data, minutes ones
min_tens  output  4  BCD load data, minutes tens
loadn  output  1  active-low load strobe to counters
en  output  1  counter enable
clr_timer  output  1  one-cycle pulse clearing the counter chain
ndigits  output  3  digits entered so far, 0..DIGITS
err  output  1  one-cycle error pulse
state  output  2  FSM state for display/debug

Behaviour:
- Reset (clr=1 at edge): state=IDLE, all digit registers 0, ndigits=0, loadn=1, en=0, clr_timer=0, err=0. Reset mid-LOAD or mid-BUSY aborts immediately; loadn returns to 1 and en to 0 on the same edge.
- States: IDLE=0, ENTRY=1, LOAD=2, BUSY=3.
- Priority when strobes coincide in one cycle: cancel > start > key_valid. Lower-priority strobes are dropped.
- Digit entry (IDLE or ENTRY, key_valid, code<=9):
  - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=code.
  - ndigits increments and the FSM enters ENTRY.
  - Takes effect on the cycle after the strobe.
- Full buffer: a digit arriving with ndigits==DIGITS is discarded, registers do not wrap, err pulses.
- Illegal code (>9): discarded, err pulses, state unchanged.
- Keys in LOAD/BUSY are ignored with no err pulse.
- start in ENTRY:
  - If sec_tens>5: err pulses, stay in ENTRY, buffer kept.
  - Otherwise go to LOAD.
- start in IDLE (no feature macro): err pulses, stay in IDLE.
- LOAD: loadn=0 for exactly one cycle with data stable, then BUSY. Data outputs hold their value through LOAD and the first BUSY cycle.
- BUSY: en=1.
  - zero=1 (sampled) -> IDLE next cycle, en=0, buffer cleared, ndigits=0.
  - zero is ignored during LOAD and during the first BUSY cycle, so the freshly loaded value can propagate.
- cancel:
  - ENTRY: clear buffer, go to IDLE.
  - BUSY: en=0, clr_timer pulses one cycle, clear buffer, go to IDLE.
  - IDLE: clr_timer pulses.
  - LOAD: completes the load pulse, then goes to IDLE with clr_timer pulsed.
- Loading 00:00 is legal. LOAD -> BUSY; zero is then seen after the guard cycle -> IDLE.

Optional Feature:
QUICK_START_EN.
- Defined: start in IDLE loads 00:(QUICK_SEC_TENS)0, i.e. 00:30 by default, into the digit registers and proceeds through LOAD/BUSY as normal.
- Also defined: start in BUSY adds 30 s. It increments sec_tens by QUICK_SEC_TENS with BCD carry into the minutes (mod-6 seconds tens, saturating at 99:59), then re-enters LOAD for one cycle.
- Undefined: start in IDLE gives an err pulse; start in BUSY is ignored.

Test Plan:
- Reset, then keys 1,2,3,0 and start -> min_tens..sec_ones=1,2,3,0, ndigits=4, loadn low exactly one cycle, en=1 from the next cycle; force zero=1 -> IDLE, en=0, ndigits=0.
- Keys 1,2,3,4,5 -> fifth key gives err pulse; registers remain 1,2,3,4 and ndigits stays 4.
- Keys 7,5 then start (sec_tens=7) -> err pulse, state stays ENTRY, loadn stays 1; cancel -> IDLE, buffer 0.
- In BUSY, cancel and start in the same cycle -> en=0, clr_timer one cycle high, state IDLE, no loadn pulse.
- key_code=12 in ENTRY -> err pulse, buffer unchanged; assert clr during LOAD -> loadn=1 and state IDLE next edge.
- QUICK_START_EN: start in IDLE -> 00:30 loaded, loadn pulses. Start again in BUSY at buffer 00:45 -> 01:15 reloaded. Undefined build: start in IDLE -> err pulse only.

Source files
------------

// File: rtl/time_entry.sv
// time_entry: keypad-side writer for the microwave mm:ss countdown chain.
// Collects BCD digits typed by the user, validates them and parallel-loads
// the mod-10/mod-6 counters. It then gates the counter enable until the
// timer reports zero or the user cancels.
//
// Optional feature macro: QUICK_START_EN
//   Defined:   start in IDLE loads 00:(QUICK_SEC_TENS)0.
//              start in BUSY adds QUICK_SEC_TENS*10 s and reloads.
//   Undefined: start in IDLE pulses err; start in BUSY is ignored.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   clr        synchronous active-high reset
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   keypad code; 0-9 are digits, 10-15 are illegal
//   start      one-cycle start strobe
//   cancel     one-cycle cancel/stop strobe
//   zero       timer chain reports 00:00
//   sec_ones   BCD load data, seconds ones
//   sec_tens   BCD load data, seconds tens
//   min_ones   BCD load data, minutes ones
//   min_tens   BCD load data, minutes tens
//   loadn      active-low load strobe to the counters
//   en         counter enable
//   clr_timer  one-cycle pulse clearing the counter chain
//   ndigits    number of digits entered so far, 0..DIGITS
//   err        one-cycle error pulse
//   state      FSM state (IDLE=0, ENTRY=1, LOAD=2, BUSY=3)

module time_entry #(
    parameter int         DIGITS         = 4,
    parameter logic [3:0] QUICK_SEC_TENS = 4'd3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       cancel,
    input  logic       zero,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       loadn,
    output logic       en,
    output logic       clr_timer,
    output logic [2:0] ndigits,
    output logic       err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        BUSY  = 2'd3
    } state_t;

    state_t cur;

    // High during the first BUSY cycle: the counters have just been
    // loaded, so their zero flag still reflects the old contents.
    logic guard;

    logic is_digit;
    logic full;

    assign is_digit = (key_code <= 4'd9);
    assign full     = (ndigits == 3'(DIGITS));
    assign state    = cur;

`ifdef QUICK_START_EN
    // Buffer plus QUICK_SEC_TENS tens of seconds, with mod-6 carry into
    // the BCD minutes and saturation at 99:59.
    logic [4:0] q_sum;
    logic [3:0] q_so;
    logic [3:0] q_st;
    logic [3:0] q_mo;
    logic [3:0] q_mt;

    always_comb begin
        q_sum = {1'b0, sec_tens} + {1'b0, QUICK_SEC_TENS};
        q_so  = sec_ones;
        q_st  = q_sum[3:0];
        q_mo  = min_ones;
        q_mt  = min_tens;
        if (q_sum >= 5'd6) begin
            q_st = 4'(q_sum - 5'd6);
            if (min_ones == 4'd9 && min_tens == 4'd9) begin
                q_so = 4'd9;
                q_st = 4'd5;
            end else if (min_ones == 4'd9) begin
                q_mo = 4'd0;
                q_mt = min_tens + 4'd1;
            end else begin
                q_mo = min_ones + 4'd1;
            end
        end
    end
`else
    wire unused_quick = ^QUICK_SEC_TENS;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            cur       <= IDLE;
            sec_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            min_ones  <= 4'd0;
            min_tens  <= 4'd0;
            ndigits   <= 3'd0;
            loadn     <= 1'b1;
            en        <= 1'b0;
            clr_timer <= 1'b0;
            err       <= 1'b0;
            guard     <= 1'b0;
        end else begin
            err       <= 1'b0;
            clr_timer <= 1'b0;
            loadn     <= 1'b1;
            case (cur)
                IDLE, ENTRY: begin
                    if (cancel) begin
                        sec_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        min_ones <= 4'd0;
                        min_tens <= 4'd0;
                        ndigits  <= 3'd0;
                        cur      <= IDLE;
                        if (cur == IDLE) begin
                            clr_timer <= 1'b1;
                        end
                    end else if (start) begin
                        if (cur == ENTRY) begin
                            if (sec_tens > 4'd5) begin
                                err <= 1'b1;
                            end else begin
                                cur   <= LOAD;
                                loadn <= 1'b0;
                            end
                        end else begin
`ifdef QUICK_START_EN
                            sec_ones <= 4'd0;
                            sec_tens <= QUICK_SEC_TENS;
                            min_ones <= 4'd0;
                            min_tens <= 4'd0;
                            cur      <= LOAD;
                            loadn    <= 1'b0;
`else
                            err <= 1'b1;
`endif
                        end
                    end else if (key_valid) begin
                        if (!is_digit || full) begin
                            err <= 1'b1;
                        end else begin
                            min_tens <= min_ones;
                            min_ones <= sec_tens;
                            sec_tens <= sec_ones;
                            sec_ones <= key_code;
                            ndigits  <= ndigits + 3'd1;
                            cur      <= ENTRY;
                        end
                    end
                end
                LOAD: begin
                    // The load pulse is already on the wire; a cancel here
                    // lets it finish and then clears the chain instead of
                    // starting the countdown.
                    if (cancel) begin
                        sec_ones  <= 4'd0;
                        sec_tens  <= 4'd0;
                        min_ones  <= 4'd0;
                        min_tens  <= 4'd0;
                        ndigits   <= 3'd0;
                        clr_timer <= 1'b1;
                        en        <= 1'b0;
                        cur       <= IDLE;
                    end else begin
                        en    <= 1'b1;
                        guard <= 1'b1;
                        cur   <= BUSY;
                    end
                end
                BUSY: begin
                    guard <= 1'b0;
                    if (cancel) begin
                        sec_ones  <= 4'd0;
                        sec_tens  <= 4'd0;
                        min_ones  <= 4'd0;
                        min_tens  <= 4'd0;
                        ndigits   <= 3'd0;
                        clr_timer <= 1'b1;
                        en        <= 1'b0;
                        cur       <= IDLE;
`ifdef QUICK_START_EN
                    end else if (start) begin
                        sec_ones <= q_so;
                        sec_tens <= q_st;
                        min_ones <= q_mo;
                        min_tens <= q_mt;
                        loadn    <= 1'b0;
                        en       <= 1'b0;
                        cur      <= LOAD;
`endif
                    end else if (zero && !guard) begin
                        sec_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        min_ones <= 4'd0;
                        min_tens <= 4'd0;
                        ndigits  <= 3'd0;
                        en       <= 1'b0;
                        cur      <= IDLE;
                    end
                end
                default: begin
                    cur <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry: table-driven, scoreboard-checked bench for time_entry.
// Each record is one clock of stimulus plus the outputs expected after it.

module tb_time_entry;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       zero = 1'b0;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       loadn;
    logic       en;
    logic       clr_timer;
    logic [2:0] ndigits;
    logic       err;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    time_entry dut (
        .clk       (clk),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .start     (start),
        .cancel    (cancel),
        .zero      (zero),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .loadn     (loadn),
        .en        (en),
        .clr_timer (clr_timer),
        .ndigits   (ndigits),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] dig;
        logic [2:0]  nd;
        logic        ldn;
        logic        en;
        logic        ct;
        logic        er;
    } exp_t;

    typedef struct {
        logic       c;
        logic       kv;
        logic [3:0] code;
        logic       s;
        logic       n;
        logic       z;
        exp_t       e;
        string      name;
    } vec_t;

    exp_t  sb_q[$];
    string nm_q[$];

    function automatic vec_t mk(
        input string name,
        input logic c, input logic kv, input logic [3:0] code,
        input logic s, input logic n, input logic z,
        input logic [1:0] es, input logic [15:0] ed, input logic [2:0] nd,
        input logic l, input logic e, input logic ct, input logic er
    );
        vec_t v;
        v.name = name;
        v.c = c; v.kv = kv; v.code = code;
        v.s = s; v.n = n; v.z = z;
        v.e.st = es; v.e.dig = ed; v.e.nd = nd;
        v.e.ldn = l; v.e.en = e; v.e.ct = ct; v.e.er = er;
        return v;
    endfunction

    task automatic step(input vec_t v);
        exp_t  want;
        exp_t  got;
        string nm;
        @(negedge clk);
        clr = v.c; key_valid = v.kv; key_code = v.code;
        start = v.s; cancel = v.n; zero = v.z;
        sb_q.push_back(v.e);
        nm_q.push_back(v.name);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        nm = nm_q.pop_front();
        got = {state, min_tens, min_ones, sec_tens, sec_ones,
               ndigits, loadn, en, clr_timer, err};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got st=%0d dig=%h nd=%0d ldn=%b en=%b ct=%b err=%b want st=%0d dig=%h nd=%0d ldn=%b en=%b ct=%b err=%b",
                nm, got.st, got.dig, got.nd, got.ldn, got.en, got.ct, got.er,
                want.st, want.dig, want.nd, want.ldn, want.en, want.ct, want.er);
        end
    endtask

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // name, clr kv code start cancel zero | st dig nd loadn en ct err
        tbl.push_back(mk("reset",     1,0,4'd0,0,0,0, 2'd0,16'h0000,3'd0,1,0,0,0));
        tbl.push_back(mk("key1",      0,1,4'd1,0,0,0, 2'd1,16'h0001,3'd1,1,0,0,0));
        tbl.push_back(mk("key2",      0,1,4'd2,0,0,0, 2'd1,16'h0012,3'd2,1,0,0,0));
        tbl.push_back(mk("key3",      0,1,4'd3,0,0,0, 2'd1,16'h0123,3'd3,1,0,0,0));
        tbl.push_back(mk("key0",      0,1,4'd0,0,0,0, 2'd1,16'h1230,3'd4,1,0,0,0));
        tbl.push_back(mk("start",     0,0,4'd0,1,0,0, 2'd2,16'h1230,3'd4,0,0,0,0));
        tbl.push_back(mk("load_zero", 0,0,4'd0,0,0,1, 2'd3,16'h1230,3'd4,1,1,0,0));
        tbl.push_back(mk("guard",     0,1,4'd5,0,0,1, 2'd3,16'h1230,3'd4,1,1,0,0));
        tbl.push_back(mk("zero_done", 0,0,4'd0,0,0,1, 2'd0,16'h0000,3'd0,1,0,0,0));
        tbl.push_back(mk("f_key1",    0,1,4'd1,0,0,0, 2'd1,16'h0001,3'd1,1,0,0,0));
        tbl.push_back(mk("f_key2",    0,1,4'd2,0,0,0, 2'd1,16'h0012,3'd2,1,0,0,0));
        tbl.push_back(mk("f_key3",    0,1,4'd3,0,0,0, 2'd1,16'h0123,3'd3,1,0,0,0));
        tbl.push_back(mk("f_key4",    0,1,4'd4,0,0,0, 2'd1,16'h1234,3'd4,1,0,0,0));
        tbl.push_back(mk("full",      0,1,4'd5,0,0,0, 2'd1,16'h1234,3'd4,1,0,0,1));
        tbl.push_back(mk("full_idle", 0,0,4'd0,0,0,0, 2'd1,16'h1234,3'd4,1,0,0,0));
        tbl.push_back(mk("f_cancel",  0,0,4'd0,0,1,0, 2'd0,16'h0000,3'd0,1,0,0,0));
        tbl.push_back(mk("b_key7",    0,1,4'd7,0,0,0, 2'd1,16'h0007,3'd1,1,0,0,0));
        tbl.push_back(mk("b_key5",    0,1,4'd5,0,0,0, 2'd1,16'h0075,3'd2,1,0,0,0));
        tbl.push_back(mk("bad_start", 0,0,4'd0,1,0,0, 2'd1,16'h0075,3'd2,1,0,0,1));
        tbl.push_back(mk("illegal12", 0,1,4'd12,0,0,0,2'd1,16'h0075,3'd2,1,0,0,1));
        tbl.push_back(mk("e_cancel",  0,0,4'd0,0,1,0, 2'd0,16'h0000,3'd0,1,0,0,0));
        tbl.push_back(mk("i_cancel",  0,0,4'd0,0,1,0, 2'd0,16'h0000,3'd0,1,0,1,0));
        tbl.push_back(mk("c_key4",    0,1,4'd4,0,0,0, 2'd1,16'h0004,3'd1,1,0,0,0));
        tbl.push_back(mk("c_key5",    0,1,4'd5,0,0,0, 2'd1,16'h0045,3'd2,1,0,0,0));
        tbl.push_back(mk("c_start",   0,0,4'd0,1,0,0, 2'd2,16'h0045,3'd2,0,0,0,0));
        tbl.push_back(mk("c_busy",    0,0,4'd0,0,0,0, 2'd3,16'h0045,3'd2,1,1,0,0));
        tbl.push_back(mk("cn_st",     0,1,4'd3,1,1,0, 2'd0,16'h0000,3'd0,1,0,1,0));
        tbl.push_back(mk("ct_pulse",  0,0,4'd0,0,0,0, 2'd0,16'h0000,3'd0,1,0,0,0));
        tbl.push_back(mk("r_key2",    0,1,4'd2,0,0,0, 2'd1,16'h0002,3'd1,1,0,0,0));
        tbl.push_back(mk("r_start",   0,0,4'd0,1,0,0, 2'd2,16'h0002,3'd1,0,0,0,0));
        tbl.push_back(mk("clr_load",  1,0,4'd0,0,0,0, 2'd0,16'h0000,3'd0,1,0,0,0));
        tbl.push_back(mk("l_key9",    0,1,4'd9,0,0,0, 2'd1,16'h0009,3'd1,1,0,0,0));
        tbl.push_back(mk("l_start",   0,0,4'd0,1,0,0, 2'd2,16'h0009,3'd1,0,0,0,0));
        tbl.push_back(mk("cn_load",   0,0,4'd0,0,1,0, 2'd0,16'h0000,3'd0,1,0,1,0));
        tbl.push_back(mk("z_key0",    0,1,4'd0,0,0,0, 2'd1,16'h0000,3'd1,1,0,0,0));
        tbl.push_back(mk("z_start",   0,0,4'd0,1,0,0, 2'd2,16'h0000,3'd1,0,0,0,0));
        tbl.push_back(mk("z_load",    0,0,4'd0,0,0,1, 2'd3,16'h0000,3'd1,1,1,0,0));
        tbl.push_back(mk("z_guard",   0,0,4'd0,0,0,1, 2'd3,16'h0000,3'd1,1,1,0,0));
        tbl.push_back(mk("z_done",    0,0,4'd0,0,0,1, 2'd0,16'h0000,3'd0,1,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

`ifdef QUICK_START_EN
        step(mk("q_start",  0,0,4'd0,1,0,0, 2'd2,16'h0030,3'd0,0,0,0,0));
        step(mk("q_busy",   0,0,4'd0,0,0,0, 2'd3,16'h0030,3'd0,1,1,0,0));
        step(mk("q_cancel", 0,0,4'd0,0,1,0, 2'd0,16'h0000,3'd0,1,0,1,0));
        step(mk("q_key4",   0,1,4'd4,0,0,0, 2'd1,16'h0004,3'd1,1,0,0,0));
        step(mk("q_key5",   0,1,4'd5,0,0,0, 2'd1,16'h0045,3'd2,1,0,0,0));
        step(mk("q_load",   0,0,4'd0,1,0,0, 2'd2,16'h0045,3'd2,0,0,0,0));
        step(mk("q_run",    0,0,4'd0,0,0,0, 2'd3,16'h0045,3'd2,1,1,0,0));
        step(mk("q_add30",  0,0,4'd0,1,0,0, 2'd2,16'h0115,3'd2,0,0,0,0));
        step(mk("q_rerun",  0,0,4'd0,0,0,0, 2'd3,16'h0115,3'd2,1,1,0,0));
        step(mk("q_end",    0,0,4'd0,0,1,0, 2'd0,16'h0000,3'd0,1,0,1,0));
`else
        step(mk("u_start",  0,0,4'd0,1,0,0, 2'd0,16'h0000,3'd0,1,0,0,1));
        step(mk("u_key4",   0,1,4'd4,0,0,0, 2'd1,16'h0004,3'd1,1,0,0,0));
        step(mk("u_key5",   0,1,4'd5,0,0,0, 2'd1,16'h0045,3'd2,1,0,0,0));
        step(mk("u_load",   0,0,4'd0,1,0,0, 2'd2,16'h0045,3'd2,0,0,0,0));
        step(mk("u_run",    0,0,4'd0,0,0,0, 2'd3,16'h0045,3'd2,1,1,0,0));
        step(mk("u_bstart", 0,0,4'd0,1,0,0, 2'd3,16'h0045,3'd2,1,1,0,0));
        step(mk("u_end",    0,0,4'd0,0,1,0, 2'd0,16'h0000,3'd0,1,0,1,0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
